hilo_mul_unit: RTL and testbench

//  Multi-cycle multiply/accumulate unit that owns the HI/LO registers. It is the consumer of the
//  6-bit ALUControl code produced by the ALU controller and executes only the HI/LO-class codes.

---
 rtl/hilo_mul_unit.sv | 171 +++++++++++++++++
 tb/tb_hilo_mul_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_unit.sv
// HI/LO multiply/accumulate unit beside the EX-stage ALU.
// Radix-2 shift-add core; the pipeline stalls while Busy is high.
module hilo_mul_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [5:0] OP_MULT  = 6'b000011;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b010011;
    localparam logic [5:0] OP_MADD  = 6'b010100;
    localparam logic [5:0] OP_MSUB  = 6'b010101;
    localparam logic [5:0] OP_MFHI  = 6'b010111;
    localparam logic [5:0] OP_MFLO  = 6'b011000;
    localparam logic [5:0] OP_MTHI  = 6'b011001;
    localparam logic [5:0] OP_MTLO  = 6'b011010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic [5:0]         op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic [2*WIDTH-1:0] acc;
    logic               is_mul;
    logic               is_single;
    logic               sgn;

    // Magnitude of a signed operand; the most-negative value maps to 2**(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] v,
        input logic             s
    );
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    always_comb begin
        is_mul = (ALUControl == OP_MULT)  || (ALUControl == OP_MULTU) ||
                 (ALUControl == OP_MUL)   || (ALUControl == OP_MADD)  ||
                 (ALUControl == OP_MSUB);
        is_single = (ALUControl == OP_MFHI) || (ALUControl == OP_MFLO) ||
                    (ALUControl == OP_MTHI) || (ALUControl == OP_MTLO);
        sgn = (ALUControl != OP_MULTU);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = (state_q == S_CALC) || (state_q == S_FIXUP);
        sum      = '0;
        acc      = {hi_q, lo_q};
        prod_fix = neg_q ? -p_q : p_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start && is_mul) begin
                    op_d    = ALUControl;
                    mcand_d = mag(A, sgn);
                    p_d     = {{WIDTH{1'b0}}, mag(B, sgn)};
                    neg_d   = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = S_CALC;
                end else if (Start && is_single) begin
                    done_d = 1'b1;
                    unique case (ALUControl)
                        OP_MFHI: result_d = hi_q;
                        OP_MFLO: result_d = lo_q;
                        OP_MTHI: hi_d     = A;
                        OP_MTLO: lo_d     = A;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                // Add the multiplicand into the upper half, then shift right.
                sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} +
                      (p_q[0] ? {1'b0, mcand_q} : '0);
                p_d   = {sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                unique case (op_q)
                    OP_MADD: {hi_d, lo_d} = acc + prod_fix;
                    OP_MSUB: {hi_d, lo_d} = acc - prod_fix;
                    OP_MUL:  result_d     = prod_fix[WIDTH-1:0];
                    default: {hi_d, lo_d} = prod_fix;
                endcase
                cnt_d   = '0;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;
    assign HI     = hi_q;
    assign LO     = lo_q;

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Directed-vector bench for hilo_mul_unit.
// Vectors and expected values are hand-computed.
module tb_hilo_mul_unit;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_MULT  = 6'b000011;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b010011;
    localparam logic [5:0] OP_MADD  = 6'b010100;
    localparam logic [5:0] OP_MSUB  = 6'b010101;
    localparam logic [5:0] OP_MFHI  = 6'b010111;
    localparam logic [5:0] OP_MFLO  = 6'b011000;
    localparam logic [5:0] OP_MTHI  = 6'b011001;
    localparam logic [5:0] OP_MTLO  = 6'b011010;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [5:0]  ALUControl = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad = 0;
    int overlap = 0;
    int lat;
    int bsy;
    int dones;

    hilo_mul_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Start(Start),
        .ALUControl(ALUControl),
        .A(A),
        .B(B),
        .Busy(Busy),
        .Done(Done),
        .Result(Result),
        .HI(HI),
        .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue a multiply at edge 0; optionally pulse Start again at cycle poke.
    task automatic run_mul(input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int poke,
                           output int l, output int nb);
        ALUControl = op;
        A = a;
        B = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A = ~a;
        B = ~b;
        ALUControl = OP_MULTU;
        l = 0;
        nb = 0;
        while (!Done && l < 100) begin
            Start = (l == poke);
            @(posedge Clk);
            #1;
            l++;
            if (Busy) nb++;
            if (Busy && Done) overlap++;
        end
        Start = 1'b0;
    endtask

    task automatic single(input logic [5:0] op, input logic [31:0] a);
        ALUControl = op;
        A = a;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A = 32'h0;
    endtask

    initial begin
        #2;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_result", Result, 0);
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        run_mul(OP_MULT, 32'hFFFFFFFD, 32'h00000007, -1, lat, bsy);
        chk("t1_lat", lat, 34);
        chk("t1_busy", bsy, 33);
        chk("t1_hi", HI, 32'hFFFFFFFF);
        chk("t1_lo", LO, 32'hFFFFFFEB);
        @(posedge Clk);
        #1;
        single(OP_MFHI, 32'h0);
        chk("b2b_mfhi", Result, 32'hFFFFFFFF);

        run_mul(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat, bsy);
        chk("t2u_lat", lat, 34);
        chk("t2u_hi", HI, 32'hFFFFFFFE);
        chk("t2u_lo", LO, 32'h00000001);
        run_mul(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat, bsy);
        chk("t2s_hi", HI, 32'h00000000);
        chk("t2s_lo", LO, 32'h00000001);

        single(OP_MTHI, 32'h00000000);
        single(OP_MTLO, 32'h00000010);
        chk("t3_mtlo", LO, 32'h00000010);
        run_mul(OP_MADD, 32'h00000002, 32'hFFFFFFFD, -1, lat, bsy);
        chk("t3_madd_hi", HI, 32'h00000000);
        chk("t3_madd_lo", LO, 32'h0000000A);
        run_mul(OP_MSUB, 32'h80000000, 32'h00000001, -1, lat, bsy);
        chk("t3_msub_hi", HI, 32'h00000000);
        chk("t3_msub_lo", LO, 32'h8000000A);

        // 0x10000 * 0x10001 = 0x1_0001_0000; low word only.
        run_mul(OP_MUL, 32'h00010000, 32'h00010001, -1, lat, bsy);
        chk("t4_result", Result, 32'h00010000);
        chk("t4_hi", HI, 32'h00000000);
        chk("t4_lo", LO, 32'h8000000A);

        single(OP_MTHI, 32'hCAFEF00D);
        chk("t5_done", Done, 1);
        chk("t5_busy", Busy, 0);
        chk("t5_hi", HI, 32'hCAFEF00D);
        single(OP_MFHI, 32'h0);
        chk("t5_mfhi", Result, 32'hCAFEF00D);
        single(OP_MFLO, 32'h0);
        chk("t5_mflo", Result, 32'h8000000A);
        single(OP_ADD, 32'h12345678);
        chk("t5_add_done", Done, 0);
        chk("t5_add_busy", Busy, 0);
        chk("t5_add_result", Result, 32'h8000000A);
        @(posedge Clk);
        #1;
        chk("t5_add_late", Done, 0);

        // Second Start at cycle 5 with different op/operands is ignored.
        run_mul(OP_MULT, 32'h00000005, 32'h00000006, 5, lat, bsy);
        chk("t6_lat", lat, 34);
        chk("t6_hi", HI, 32'h00000000);
        chk("t6_lo", LO, 32'h0000001E);

        single(OP_MTHI, 32'hCAFEF00D);
        ALUControl = OP_MULT;
        A = 32'h00000003;
        B = 32'h00000004;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge Clk);
        #3;
        chk("t6_busy_pre", Busy, 1);
        Rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", Busy, 0);
        chk("t6_rst_hi", HI, 0);
        chk("t6_rst_lo", LO, 0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (Done) dones++;
        end
        chk("t6_no_done", dones, 0);
        chk("t6_idle_busy", Busy, 0);

        chk("busy_done_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
